// File: rtl/rf_port_arbiter.sv
// Round-robin arbiter sharing the single register-file access port among N_REQ requesters.
// Each grant runs exactly one read or write; every output is registered.
module rf_port_arbiter #(
    parameter int N_REQ  = 3,
    parameter int W      = 8,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     req_we,
    input  logic [3*N_REQ-1:0]   req_sel,
    input  logic [W*N_REQ-1:0]   req_wd,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     done,
    output logic [N_REQ-1:0]     err,
    output logic [W-1:0]         rdata,
    output logic                 busy,
    output logic [W-1:0]         rf_d,
    output logic                 rf_as,
    output logic                 rf_bs,
    output logic                 rf_cs,
    output logic                 rf_ds,
    output logic                 rf_fs,
    output logic                 rf_re,
    output logic                 rf_we,
    input  logic [W-1:0]         rf_p
);

    localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [IDXW-1:0]    rr_last, rr_nx;
    logic [N_REQ-1:0]   op_hot, hot_nx;
    logic               op_we, we_nx;
    logic               op_err, op_err_nx;
    logic [2:0]         cnt, cnt_nx;

    logic [N_REQ-1:0]   gnt_nx, done_nx, err_nx;
    logic [W-1:0]       rdata_nx, rf_d_nx;
    logic               busy_nx, re_nx, wes_nx;
    logic [4:0]         sel_nx;

    logic               found;
    logic [IDXW-1:0]    win;
    logic [IDXW:0]      pos;
    logic [2:0]         sel_w;
    logic [W-1:0]       wd_w;
    logic               we_w;

    // Handshake: a requester holds req (with we/sel/wd stable) until it sees gnt, then
    // drops it or presents a new op on the next edge; done/err close out the op.
    always_comb begin
        state_nx  = state;
        rr_nx     = rr_last;
        hot_nx    = op_hot;
        we_nx     = op_we;
        op_err_nx = op_err;
        cnt_nx    = cnt;
        gnt_nx    = '0;
        done_nx   = '0;
        err_nx    = '0;
        rdata_nx  = rdata;
        rf_d_nx   = '0;
        sel_nx    = '0;
        re_nx     = 1'b0;
        wes_nx    = 1'b0;
        found     = 1'b0;
        win       = '0;
        pos       = '0;
        sel_w     = '0;
        wd_w      = '0;
        we_w      = 1'b0;

        // Scan starts just after the last winner and wraps, giving strict round-robin.
        for (int i = 0; i < N_REQ; i++) begin
            pos = {1'b0, rr_last} + (IDXW+1)'(i + 1);
            if (pos >= (IDXW+1)'(N_REQ))
                pos = pos - (IDXW+1)'(N_REQ);
            if (!found && req[pos[IDXW-1:0]]) begin
                found = 1'b1;
                win   = pos[IDXW-1:0];
            end
        end

        for (int i = 0; i < N_REQ; i++) begin
            if (win == IDXW'(i)) begin
                sel_w = req_sel[3*i +: 3];
                wd_w  = req_wd[W*i +: W];
                we_w  = req_we[i];
            end
        end

        case (state)
            IDLE: begin
                if (found) begin
                    state_nx = ISSUE;
                    rr_nx    = win;
                    hot_nx   = N_REQ'(1) << win;
                    we_nx    = we_w;
                    gnt_nx   = hot_nx;
                    if (sel_w > 3'd4) begin
                        op_err_nx = 1'b1;
                        err_nx    = hot_nx;
                    end else begin
                        op_err_nx = 1'b0;
                        sel_nx    = 5'd1 << sel_w;
                        wes_nx    = we_w;
                        re_nx     = !we_w;
                        rf_d_nx   = we_w ? wd_w : '0;
                    end
                end
            end
            ISSUE: begin
                if (op_err || op_we) begin
                    state_nx = IDLE;
                    done_nx  = op_err ? '0 : op_hot;
                end else if (RD_LAT == 0) begin
                    state_nx = IDLE;
                    rdata_nx = rf_p;
                    done_nx  = op_hot;
                end else begin
                    state_nx = WAIT;
                    cnt_nx   = 3'(RD_LAT - 1);
                end
            end
            WAIT: begin
                if (cnt == 3'd0) begin
                    state_nx = IDLE;
                    rdata_nx = rf_p;
                    done_nx  = op_hot;
                end else begin
                    cnt_nx = cnt - 3'd1;
                end
            end
            default: state_nx = IDLE;
        endcase

        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            rr_last <= IDXW'(N_REQ - 1);
            op_hot  <= '0;
            op_we   <= 1'b0;
            op_err  <= 1'b0;
            cnt     <= '0;
            gnt     <= '0;
            done    <= '0;
            err     <= '0;
            rdata   <= '0;
            busy    <= 1'b0;
            rf_d    <= '0;
            rf_as   <= 1'b0;
            rf_bs   <= 1'b0;
            rf_cs   <= 1'b0;
            rf_ds   <= 1'b0;
            rf_fs   <= 1'b0;
            rf_re   <= 1'b0;
            rf_we   <= 1'b0;
        end else begin
            state   <= state_nx;
            rr_last <= rr_nx;
            op_hot  <= hot_nx;
            op_we   <= we_nx;
            op_err  <= op_err_nx;
            cnt     <= cnt_nx;
            gnt     <= gnt_nx;
            done    <= done_nx;
            err     <= err_nx;
            rdata   <= rdata_nx;
            busy    <= busy_nx;
            rf_d    <= rf_d_nx;
            rf_as   <= sel_nx[0];
            rf_bs   <= sel_nx[1];
            rf_cs   <= sel_nx[2];
            rf_ds   <= sel_nx[3];
            rf_fs   <= sel_nx[4];
            rf_re   <= re_nx;
            rf_we   <= wes_nx;
        end
    end

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Bench for rf_port_arbiter: RD_LAT=1 instance with an rf model and event scoreboard,
// plus an RD_LAT=3 instance for reset during a read wait.
module tb_rf_port_arbiter;

    localparam int N = 3;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [N-1:0]     req, req_we;
    logic [3*N-1:0]   req_sel;
    logic [W*N-1:0]   req_wd;
    logic [N-1:0]     gnt, done, err;
    logic [W-1:0]     rdata, rf_d, rf_p;
    logic             busy, rf_as, rf_bs, rf_cs, rf_ds, rf_fs, rf_re, rf_we;

    logic             rst3;
    logic [N-1:0]     req3, req_we3;
    logic [3*N-1:0]   req_sel3;
    logic [W*N-1:0]   req_wd3;
    logic [N-1:0]     gnt3, done3, err3;
    logic [W-1:0]     rdata3, rf_d3, rf_p3;
    logic             busy3, rf_as3, rf_bs3, rf_cs3, rf_ds3, rf_fs3, rf_re3, rf_we3;

    rf_port_arbiter #(.N_REQ(N), .W(W), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_sel(req_sel), .req_wd(req_wd),
        .gnt(gnt), .done(done), .err(err), .rdata(rdata), .busy(busy), .rf_d(rf_d),
        .rf_as(rf_as), .rf_bs(rf_bs), .rf_cs(rf_cs), .rf_ds(rf_ds), .rf_fs(rf_fs),
        .rf_re(rf_re), .rf_we(rf_we), .rf_p(rf_p)
    );

    rf_port_arbiter #(.N_REQ(N), .W(W), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst3), .req(req3), .req_we(req_we3), .req_sel(req_sel3), .req_wd(req_wd3),
        .gnt(gnt3), .done(done3), .err(err3), .rdata(rdata3), .busy(busy3), .rf_d(rf_d3),
        .rf_as(rf_as3), .rf_bs(rf_bs3), .rf_cs(rf_cs3), .rf_ds(rf_ds3), .rf_fs(rf_fs3),
        .rf_re(rf_re3), .rf_we(rf_we3), .rf_p(rf_p3)
    );

    logic [4:0]  rf_selv, rf_selv3;
    logic [32:0] outs, outs3;
    assign rf_selv  = {rf_fs, rf_ds, rf_cs, rf_bs, rf_as};
    assign rf_selv3 = {rf_fs3, rf_ds3, rf_cs3, rf_bs3, rf_as3};
    assign outs  = {gnt, done, err, rdata, busy, rf_d, rf_selv, rf_re, rf_we};
    assign outs3 = {gnt3, done3, err3, rdata3, busy3, rf_d3, rf_selv3, rf_re3, rf_we3};

    int           n_checks = 0;
    int           n_errors = 0;
    logic [14:0]  exp_q[$];
    logic [14:0]  mon_e;
    logic [W-1:0] last_rd;
    logic [W-1:0] rf_mem [0:4];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard entry: {is_done, requester one-hot, err one-hot, rdata}
    function automatic logic [14:0] ev(input logic kind, input logic [N-1:0] hot,
                                       input logic [N-1:0] e, input logic [W-1:0] d);
        return {kind, hot, e, d};
    endfunction

    // Register file model: write at the edge ending ISSUE, registered read data held.
    always @(posedge clk) begin
        if (!rst) begin
            rf_mem[0] <= 8'h11;
            rf_mem[1] <= 8'h22;
            rf_mem[2] <= 8'h33;
            rf_mem[3] <= 8'h44;
            rf_mem[4] <= 8'h3C;
            rf_p      <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (rf_selv[i]) begin
                    if (rf_we) rf_mem[i] <= rf_d;
                    if (rf_re) rf_p <= rf_mem[i];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("inv_sel_onehot", 64'($onehot0(rf_selv)), 64'(1));
            check("inv_re_we", 64'(rf_re & rf_we), 64'(0));
            check("inv_gnt_done", 64'($onehot0(gnt | done)), 64'(1));
            check("inv_strobe_gnt", 64'((rf_re | rf_we) & (gnt == '0)), 64'(0));
            if ((gnt | done) != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", 64'({gnt, done}), 64'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("event", (done != '0) ? 64'({1'b1, done, err, rdata})
                                                : 64'({1'b0, gnt, err, 8'h00}), 64'(mon_e));
                end
            end
        end
    end

    task automatic do_op(input int idx, input logic we, input logic [2:0] sel,
                         input logic [W-1:0] wd, input logic [W-1:0] rd_exp);
        logic [N-1:0] hot;
        logic         legal;
        logic [4:0]   exp_sel;
        hot     = N'(1) << idx;
        legal   = (sel <= 3'd4);
        exp_sel = legal ? (5'd1 << sel) : 5'd0;
        @(negedge clk);
        req[idx]             = 1'b1;
        req_we[idx]          = we;
        req_sel[3*idx +: 3]  = sel;
        req_wd[W*idx +: W]   = wd;
        exp_q.push_back(ev(1'b0, hot, legal ? '0 : hot, '0));
        if (legal) begin
            if (!we) last_rd = rd_exp;
            exp_q.push_back(ev(1'b1, hot, '0, last_rd));
        end
        @(negedge clk);
        req[idx] = 1'b0;
        check("issue_gnt", 64'(gnt), 64'(hot));
        check("issue_err", 64'(err), legal ? 64'(0) : 64'(hot));
        check("issue_sel", 64'(rf_selv), 64'(exp_sel));
        check("issue_strobe", 64'({rf_re, rf_we}), legal ? 64'({!we, we}) : 64'(0));
        check("issue_rf_d", 64'(rf_d), (legal && we) ? 64'(wd) : 64'(0));
        if (!legal) begin
            repeat (2) begin
                @(negedge clk);
                check("illegal_no_done", 64'(done), 64'(0));
            end
        end else if (we) begin
            @(negedge clk);
            check("wr_done", 64'(done), 64'(hot));
            check("wr_idle", 64'(busy), 64'(0));
        end else begin
            @(negedge clk);
            check("rd_wait", 64'({busy, done}), 64'(4'b1000));
            @(negedge clk);
            check("rd_done", 64'(done), 64'(hot));
            check("rd_data", 64'(rdata), 64'(rd_exp));
        end
    endtask

    // Requesters in mask keep requesting writes, dropping req only in their gnt cycle.
    task automatic arb_run(input logic [N-1:0] mask, input int n);
        int got = 0;
        int cyc = 0;
        for (int i = 0; i < N; i++) begin
            req_we[i]           = 1'b1;
            req_sel[3*i +: 3]   = 3'(i);
            req_wd[W*i +: W]    = 8'($urandom_range(0, 255));
        end
        while (got < n && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (gnt != '0) got++;
            for (int i = 0; i < N; i++) req[i] = mask[i] & !gnt[i];
        end
        req = '0;
        check("arb_grants", 64'(got), 64'(n));
        repeat (3) @(negedge clk);
    endtask

    task automatic push_writes(input int a, input int b, input int c, input int cnt);
        int ord[3];
        ord = '{a, b, c};
        for (int k = 0; k < cnt; k++) begin
            exp_q.push_back(ev(1'b0, N'(1) << ord[k % 3], '0, '0));
            exp_q.push_back(ev(1'b1, N'(1) << ord[k % 3], '0, last_rd));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] rp;
        rst = 1'b0; rst3 = 1'b0; last_rd = '0;
        req3 = '0; req_we3 = '0; req_sel3 = '0; req_wd3 = '0; rf_p3 = '0;

        // Reset with random inputs: everything must stay 0.
        repeat (4) begin
            req     = 3'($urandom_range(0, 7));
            req_we  = 3'($urandom_range(0, 7));
            req_sel = 9'($urandom_range(0, 511));
            req_wd  = 24'($urandom);
            @(negedge clk);
            check("reset_outputs", 64'(outs), 64'(0));
        end
        req = '0; req_we = '0; req_sel = '0; req_wd = '0;
        rst = 1'b1; rst3 = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("release_idle", 64'({gnt, busy}), 64'(0));
        end

        do_op(0, 1'b1, 3'd0, 8'h5A, 8'h00);
        do_op(1, 1'b0, 3'd4, 8'h00, 8'h3C);
        do_op(2, 1'b0, 3'd0, 8'h00, 8'h5A);
        do_op(2, 1'b1, 3'd6, 8'hEE, 8'h00);

        push_writes(0, 1, 2, 6);
        arb_run(3'b111, 6);
        do_op(0, 1'b1, 3'd3, 8'hC3, 8'h00);
        push_writes(2, 0, 0, 2);
        arb_run(3'b101, 2);

        // Reset while the RD_LAT=3 instance waits on a read.
        rf_p3 = 8'h11;
        @(negedge clk);
        req3[0] = 1'b1; req_we3[0] = 1'b0; req_sel3[2:0] = 3'd1;
        @(negedge clk);
        req3 = '0;
        check("w3_issue", 64'({gnt3, rf_selv3, rf_re3, rf_we3}), 64'({3'b001, 5'b00010, 2'b10}));
        @(negedge clk);
        check("w3_busy", 64'({busy3, done3}), 64'(4'b1000));
        #2 rst3 = 1'b0;
        #1 check("w3_async_reset", 64'(outs3), 64'(0));
        repeat (2) @(negedge clk);
        rst3 = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("w3_aborted_no_done", 64'({done3, busy3}), 64'(0));
        end
        rp = 8'($urandom_range(1, 254));
        rf_p3 = rp;
        @(negedge clk);
        req3[1] = 1'b1; req_we3[1] = 1'b0; req_sel3[5:3] = 3'd1;
        @(negedge clk);
        req3 = '0;
        check("w3_gnt", 64'({gnt3, rf_selv3, rf_re3}), 64'({3'b010, 5'b00010, 1'b1}));
        repeat (3) begin
            @(negedge clk);
            check("w3_wait", 64'({done3, rdata3}), 64'(0));
        end
        @(negedge clk);
        check("w3_done", 64'(done3), 64'(3'b010));
        check("w3_rdata", 64'(rdata3), 64'(rp));

        repeat (4) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
